// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the vending controller; purely combinational.
// No latency and no flow control: functions only.
package vm_pkg;

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam logic [1:0] COIN_10  = 2'd0;
    localparam logic [1:0] COIN_20  = 2'd1;
    localparam logic [1:0] COIN_50  = 2'd2;
    localparam logic [1:0] COIN_100 = 2'd3;

    function automatic logic [8:0] coin_value(input logic [1:0] ctype);
        case (ctype)
            COIN_10:  coin_value = 9'd10;
            COIN_20:  coin_value = 9'd20;
            COIN_50:  coin_value = 9'd50;
            default:  coin_value = 9'd100;
        endcase
    endfunction

    // Greedy refund: biggest coin that does not exceed the remaining credit.
    function automatic logic [1:0] largest_coin(input logic [8:0] credit);
        if (credit >= 9'd100)
            largest_coin = COIN_100;
        else if (credit >= 9'd50)
            largest_coin = COIN_50;
        else if (credit >= 9'd20)
            largest_coin = COIN_20;
        else
            largest_coin = COIN_10;
    endfunction

endpackage

// File: rtl/vm_timeout.sv
// Idle counter: runs while run=1, cleared by clr or !run; expire pulses combinationally
// on the cycle the count sits at TIMEOUT-1, then the count wraps to zero. No backpressure.
module vm_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            expire = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vm_ctrl.sv
// Vending controller: coin credit, product vend handshake, greedy coin refund.
// All outputs registered, one cycle after the input; vend/chg requests hold until acked.
module vm_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE0     = 120,
    parameter int PRICE1     = 150,
    parameter int PRICE2     = 200,
    parameter int PRICE3     = 250,
    parameter int MAX_CREDIT = 300,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    output logic       vend_req,
    output logic [1:0] vend_id,
    input  logic       vend_ack,
    output logic       chg_req,
    output logic [1:0] chg_coin,
    input  logic       chg_ack,
    output logic [8:0] credit,
    output logic       coin_reject,
    output logic       no_funds,
    output logic       busy
);

    function automatic logic [8:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = 9'(PRICE0);
            2'd1:    price_of = 9'(PRICE1);
            2'd2:    price_of = 9'(PRICE2);
            default: price_of = 9'(PRICE3);
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [8:0] credit_q, credit_d;
    logic       vend_req_q, vend_req_d;
    logic [1:0] vend_id_q, vend_id_d;
    logic       chg_req_q, chg_req_d;
    logic [1:0] chg_coin_q, chg_coin_d;
    logic       coin_reject_q, coin_reject_d;
    logic       no_funds_q, no_funds_d;
    logic       busy_q, busy_d;

    logic       tmo_clr, tmo_expire, refund;
    logic [9:0] coin_sum;
    logic [8:0] sel_price;
    logic       coin_fits, sel_ok;

    // Ten-bit sum so a coin on top of a full 511 ceiling cannot wrap.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
    assign coin_fits = coin_sum <= 10'(MAX_CREDIT);
    assign sel_price = price_of(sel_id);
    assign sel_ok    = credit_q >= sel_price;

    vm_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == CREDIT),
        .clr    (tmo_clr),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_req_d    = vend_req_q;
        vend_id_d     = vend_id_q;
        chg_req_d     = chg_req_q;
        chg_coin_d    = chg_coin_q;
        coin_reject_d = 1'b0;
        no_funds_d    = 1'b0;
        tmo_clr       = 1'b0;
        refund        = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    refund        = (state_q == CREDIT);
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (state_q == CREDIT && sel_ok) begin
                        credit_d   = credit_q - sel_price;
                        vend_req_d = 1'b1;
                        vend_id_d  = sel_id;
                        state_d    = VEND;
                    end else begin
                        no_funds_d = 1'b1;
                        tmo_clr    = 1'b1;
                    end
                end else if (coin_valid) begin
                    tmo_clr = 1'b1;
                    if (coin_fits) begin
                        credit_d = coin_sum[8:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else begin
                    refund = tmo_expire;
                end
                if (refund) begin
                    if (credit_q != '0) begin
                        state_d    = CHANGE;
                        chg_req_d  = 1'b1;
                        chg_coin_d = largest_coin(credit_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                if (vend_req_q && vend_ack) begin
                    vend_req_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d    = CHANGE;
                        chg_req_d  = 1'b1;
                        chg_coin_d = largest_coin(credit_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                // After each ack the request rests one cycle before the next coin.
                if (chg_req_q) begin
                    if (chg_ack) begin
                        credit_d  = credit_q - coin_value(chg_coin_q);
                        chg_req_d = 1'b0;
                    end
                end else if (credit_q == '0) begin
                    state_d = IDLE;
                end else begin
                    chg_req_d  = 1'b1;
                    chg_coin_d = largest_coin(credit_q);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            vend_req_q    <= 1'b0;
            vend_id_q     <= '0;
            chg_req_q     <= 1'b0;
            chg_coin_q    <= '0;
            coin_reject_q <= 1'b0;
            no_funds_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_req_q    <= vend_req_d;
            vend_id_q     <= vend_id_d;
            chg_req_q     <= chg_req_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            no_funds_q    <= no_funds_d;
            busy_q        <= busy_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign vend_id     = vend_id_q;
    assign chg_req     = chg_req_q;
    assign chg_coin    = chg_coin_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign no_funds    = no_funds_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vm_ctrl.sv
// Bench for vm_ctrl: directed scenarios plus random coin/select/cancel traffic
// checked against a credit-level model of the machine.
module tb_vm_ctrl;

    localparam int MAXC = 300;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid, sel_valid, cancel, vend_ack, chg_ack;
    logic [1:0] coin_type, sel_id;
    logic       vend_req, chg_req, coin_reject, no_funds, busy;
    logic [1:0] vend_id, chg_coin;
    logic [8:0] credit;

    int n_checks = 0;
    int n_errors = 0;
    int m_credit = 0;
    int cval[4] = '{10, 20, 50, 100};
    int pval[4] = '{120, 150, 200, 250};

    vm_ctrl #(
        .PRICE0(120), .PRICE1(150), .PRICE2(200), .PRICE3(250),
        .MAX_CREDIT(MAXC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .vend_req(vend_req), .vend_id(vend_id), .vend_ack(vend_ack),
        .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
        .credit(credit), .coin_reject(coin_reject), .no_funds(no_funds), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resync();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_credit = 0;
    endtask

    task automatic insert_coin(input int ct);
        bit accept;
        coin_valid = 1'b1;
        coin_type  = 2'(ct);
        tick();
        coin_valid = 1'b0;
        accept = (m_credit + cval[ct] <= MAXC);
        check_val("coin_reject", coin_reject, accept ? 0 : 1);
        if (accept) m_credit += cval[ct];
        check_val("credit_after_coin", credit, m_credit);
        check_val("busy_after_coin", busy, 0);
    endtask

    // Pays out m_credit as greedy coins, occasionally pushing a coin in mid-refund.
    task automatic collect_change();
        int c, exp_coin, n, d;
        bit cv;
        bit ok;
        c  = m_credit;
        ok = 1'b1;
        while (c > 0 && ok) begin
            exp_coin = (c >= 100) ? 3 : (c >= 50) ? 2 : (c >= 20) ? 1 : 0;
            n = 0;
            while (!chg_req && n < 4) begin
                tick();
                n++;
            end
            check_val("chg_req_up", chg_req, 1);
            if (chg_req !== 1'b1) begin
                ok = 1'b0;
            end else begin
                check_val("chg_coin", chg_coin, exp_coin);
                check_val("busy_change", busy, 1);
                check_val("credit_change", credit, c);
                d = $urandom_range(0, 2);
                repeat (d) begin
                    cv = 1'($urandom_range(0, 1));
                    coin_valid = cv;
                    coin_type  = 2'($urandom_range(0, 3));
                    tick();
                    coin_valid = 1'b0;
                    check_val("coin_reject_change", coin_reject, cv);
                    check_val("chg_req_hold", chg_req, 1);
                    check_val("credit_hold", credit, c);
                end
                chg_ack = 1'b1;
                tick();
                chg_ack = 1'b0;
                c -= cval[exp_coin];
                check_val("chg_req_drop", chg_req, 0);
                check_val("credit_after_ack", credit, c);
            end
        end
        if (!ok) begin
            resync();
        end else begin
            m_credit = 0;
            n = 0;
            while (busy && n < 4) begin
                tick();
                n++;
            end
            check_val("busy_end_change", busy, 0);
            check_val("credit_end_change", credit, 0);
            check_val("chg_req_end", chg_req, 0);
        end
    endtask

    task automatic serve_vend();
        int d;
        d = $urandom_range(0, 3);
        repeat (d) begin
            tick();
            check_val("vend_req_hold", vend_req, 1);
        end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        check_val("vend_req_drop", vend_req, 0);
        if (m_credit > 0)
            collect_change();
        else
            check_val("busy_after_vend", busy, 0);
    endtask

    task automatic select(input int id, input bit with_coin);
        sel_valid  = 1'b1;
        sel_id     = 2'(id);
        coin_valid = with_coin;
        coin_type  = 2'($urandom_range(0, 3));
        tick();
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        check_val("sel_coin_reject", coin_reject, with_coin);
        if (m_credit >= pval[id]) begin
            m_credit -= pval[id];
            check_val("vend_req", vend_req, 1);
            check_val("vend_id", vend_id, id);
            check_val("credit_vend", credit, m_credit);
            check_val("no_funds_ok", no_funds, 0);
            check_val("busy_vend", busy, 1);
            serve_vend();
        end else begin
            check_val("no_funds", no_funds, 1);
            check_val("vend_req_refused", vend_req, 0);
            check_val("credit_refused", credit, m_credit);
        end
    endtask

    task automatic cancel_op(input bit with_coin, input bit with_sel);
        cancel     = 1'b1;
        coin_valid = with_coin;
        coin_type  = 2'($urandom_range(0, 3));
        sel_valid  = with_sel;
        sel_id     = 2'($urandom_range(0, 3));
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        check_val("cancel_coin_reject", coin_reject, with_coin);
        check_val("cancel_no_funds", no_funds, 0);
        check_val("cancel_vend_req", vend_req, 0);
        if (m_credit > 0) begin
            check_val("busy_cancel", busy, 1);
            collect_change();
        end else begin
            check_val("busy_cancel_idle", busy, 0);
            check_val("chg_req_cancel_idle", chg_req, 0);
        end
    endtask

    initial begin
        int r;
        coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0; sel_id = 2'd0;
        cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_credit", credit, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_vend_req", vend_req, 0);
        check_val("rst_chg_req", chg_req, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 100 + 50, buy product 0, refund 30 as 20 then 10.
        insert_coin(3);
        insert_coin(2);
        select(0, 1'b0);

        // 100 is short for product 2.
        insert_coin(3);
        select(2, 1'b0);
        cancel_op(1'b0, 1'b0);

        // Fill to the ceiling, then one more coin bounces.
        insert_coin(3); insert_coin(3); insert_coin(3);
        insert_coin(0);
        cancel_op(1'b0, 1'b0);

        // Cancel with a coin in the same cycle: coin refused, 70 refunds as 50 + 20.
        insert_coin(2); insert_coin(1);
        cancel_op(1'b1, 1'b0);

        // Inactivity refund after TMO cycles in CREDIT.
        insert_coin(1);
        for (int i = 1; i <= TMO; i++) begin
            tick();
            if (i == TMO - 1) check_val("tmo_not_yet", busy, 0);
        end
        check_val("tmo_busy", busy, 1);
        check_val("tmo_chg_req", chg_req, 1);
        check_val("tmo_chg_coin", chg_coin, 1);
        coin_valid = 1'b1;
        coin_type  = 2'd3;
        tick();
        coin_valid = 1'b0;
        check_val("tmo_coin_reject", coin_reject, 1);
        check_val("tmo_credit_hold", credit, 20);
        collect_change();

        // Reset in the middle of an 80 sen refund.
        insert_coin(2); insert_coin(1); insert_coin(0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_val("pre_rst_chg_coin", chg_coin, 2);
        check_val("pre_rst_credit", credit, 80);
        #3 rst = 1'b1;
        #1;
        check_val("mid_rst_credit", credit, 0);
        check_val("mid_rst_chg_req", chg_req, 0);
        check_val("mid_rst_chg_coin", chg_coin, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_reject", coin_reject, 0);
        check_val("mid_rst_no_funds", no_funds, 0);
        check_val("mid_rst_vend", {29'd0, vend_req, vend_id}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_credit = 0;
        tick();
        check_val("post_rst_chg_req", chg_req, 0);
        check_val("post_rst_busy", busy, 0);
        tick();
        check_val("post_rst_chg_req2", chg_req, 0);
        check_val("post_rst_credit", credit, 0);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                insert_coin($urandom_range(0, 3));
            end else if (r < 80) begin
                select($urandom_range(0, 3), $urandom_range(0, 4) == 0);
            end else if (r < 92) begin
                cancel_op($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            end else begin
                vend_ack = 1'b1;
                chg_ack  = 1'b1;
                tick();
                vend_ack = 1'b0;
                chg_ack  = 1'b0;
                check_val("stray_ack_credit", credit, m_credit);
                check_val("stray_ack_vend", vend_req, 0);
                check_val("stray_ack_chg", chg_req, 0);
                insert_coin($urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        check_val("final_credit", credit, m_credit);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vm_ctrl.md
Name: vm_ctrl

Overview:
Vending machine controller. Accepts coins and builds credit, then takes a product selection and drives the product dispenser through a req/ack handshake. Remaining credit is returned through the coin hopper, one coin per handshake. Sits between the coin validator / keypad front-end and the dispenser and hopper actuators.

Parameters:
PRICE0, 120, price of product 0 in sen (multiple of 10)
PRICE1, 150, price of product 1 in sen
PRICE2, 200, price of product 2 in sen
PRICE3, 250, price of product 3 in sen
MAX_CREDIT, 300, credit ceiling in sen; must be >= largest price and <= 511
TIMEOUT, 1000000, idle cycles before automatic refund (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle pulse, coin inserted
coin_type  in  2  0=10, 1=20, 2=50, 3=100 sen
sel_valid  in  1  one-cycle pulse, product selected
sel_id  in  2  product index 0..3
cancel  in  1  one-cycle pulse, refund request
vend_req  out  1  dispense request, level
vend_id  out  2  product to dispense, stable while vend_req=1
vend_ack  in  1  dispenser done, one-cycle pulse
chg_req  out  1  hopper request, level
chg_coin  out  2  coin to eject (same encoding as coin_type), stable while chg_req=1
chg_ack  in  1  hopper ejected coin, one-cycle pulse
credit  out  9  current credit in sen, registered
coin_reject  out  1  one-cycle pulse, coin refused (validator returns it)
no_funds  out  1  one-cycle pulse, selection refused
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async, rst=1): state=IDLE, credit=0. vend_req, vend_id, chg_req, chg_coin, coin_reject, no_funds and busy are all 0. Credit held at reset is lost by design.
- States: IDLE (credit=0), CREDIT, VEND, CHANGE. All outputs are registered; every response appears the cycle after the input.
- IDLE/CREDIT, coin_valid:
  - Accept if credit+value <= MAX_CREDIT. credit updates next cycle; IDLE->CREDIT.
  - Otherwise pulse coin_reject.
- IDLE/CREDIT input priority: cancel > sel_valid > coin_valid. A coin arriving in the same cycle as cancel or sel_valid is rejected (coin_reject=1). A sel_valid in the same cycle as cancel is ignored.
- CREDIT, sel_valid:
  - If credit >= PRICE[sel_id]: credit -= price, vend_id=sel_id, vend_req=1, ->VEND.
  - Otherwise pulse no_funds and stay in CREDIT.
- IDLE, sel_valid: pulse no_funds.
- IDLE, cancel: ignored.
- CREDIT, cancel: ->CHANGE. If credit=0 (unreachable by construction), go to IDLE instead.
- VEND:
  - Hold vend_req until vend_ack. On ack, drop vend_req the next cycle; ->CHANGE if credit>0, else ->IDLE.
  - Coins arriving in VEND or CHANGE are rejected. sel_valid and cancel are ignored. There is no vend timeout.
- CHANGE:
  - Greedy selection: chg_coin = largest of 100/50/20/10 that is <= credit. Assert chg_req.
  - On chg_ack: credit -= coin value, and chg_req drops for exactly one cycle.
  - Then re-evaluate. If credit=0 ->IDLE, otherwise issue the next coin.
  - Example: 180 sen refunds as 100, 50, 20, 10 (4 handshakes).
- Idle timeout:
  - A counter runs only in CREDIT and clears on any accepted coin, refused coin or refused selection.
  - When it reaches TIMEOUT-1: ->CHANGE, refunding all credit.
- Width rules:
  - credit is 9 bits unsigned and never exceeds MAX_CREDIT or underflows.
  - Subtraction happens only after the >= check.
  - All values are multiples of 10.
- An ack arriving without a matching outstanding request is ignored.
- busy = (state==VEND) or (state==CHANGE).

Decomposition:
- Package vm_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE)
  - coin encoding constants COIN_10/20/50/100
  - function coin_value(type) -> 9-bit sen
  - function largest_coin(credit) -> 2-bit code
- One sub-module: vm_timeout, a loadable idle counter with clear input and expire pulse, parameterised by TIMEOUT.
- Price lookup and the FSM stay in vm_ctrl.

Test Plan:
- Reset mid-CHANGE with credit=80 -> every output 0 and credit=0 during reset; IDLE after release, with no chg_req.
- Insert 100, 50, sel 0 (120) -> credit 100, 150; vend_req=1, vend_id=0, credit=30. After vend_ack: chg_coin=20 ack, then chg_coin=10 ack. Ends IDLE, credit=0.
- Credit 100, sel 2 (200) -> no_funds pulse, credit unchanged at 100, stays in CREDIT.
- Insert 100,100,100 then 10 with MAX_CREDIT=300 -> credit=300; the 10 gets coin_reject, credit stays 300.
- Credit 70, cancel together with coin_valid -> coin_reject=1. Change issued as 50 then 20; busy high throughout.
- TIMEOUT=16, credit 20, no activity -> CHANGE entered after 16 cycles, chg_coin=20. A coin inserted during CHANGE is rejected.
